f_response_checker: RTL

Self-checking response engine for the 4-input function F = AC + ABC' + BD + A'C'D'.
- Sequentially drives all 16 input vectors {A,B,C,D} = 0000..1111 into the unit under check.
- Samples the unit's F after a programmable settle time and compares it against a golden truth table.
- Reports pass/fail, mismatch count and first failing vector.
- Sits on the sink side of the function: it reads F back and judges it, where the stimulus source only writes vectors.

---
 rtl/f_response_checker.sv | 137 +++++++++++++
 1 files changed

// File: rtl/f_response_checker.sv
// Sweep engine for F = AC + ABC' + BD + A'C'D': drives all 16 {A,B,C,D} vectors, samples f_in, tallies mismatches.
// Optional per-vector mismatch map on port err_map when F_CHK_ERR_MAP_EN is defined.
module f_response_checker #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [15:0] GOLDEN     = 16'hFCB1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f_in,
    output logic       vec_a,
    output logic       vec_b,
    output logic       vec_c,
    output logic       vec_d,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic       first_err_vld,
    output logic [3:0] first_err_vec
`ifdef F_CHK_ERR_MAP_EN
    ,
    output logic [15:0] err_map
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

    state_t     state, state_nxt;
    logic [3:0] vector;
    logic [3:0] settle_cnt;
    logic       accept;
    logic       mismatch;

    assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
    assign mismatch = (state == S_SAMPLE) && (f_in != GOLDEN[vector]);

    assign vec_a = vector[3];
    assign vec_b = vector[2];
    assign vec_c = vector[1];
    assign vec_d = vector[0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next state defaults to current state first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = S_DRIVE;
            end
            S_DRIVE: begin
                state_nxt = (SETTLE_CYC == 0) ? S_SAMPLE : S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                state_nxt = (vector == 4'hF) ? S_DONE : S_DRIVE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vector        <= '0;
            settle_cnt    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_vec <= '0;
`ifdef F_CHK_ERR_MAP_EN
            err_map       <= '0;
`endif
        end else if (accept) begin
            vector        <= '0;
            settle_cnt    <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_vec <= '0;
`ifdef F_CHK_ERR_MAP_EN
            err_map       <= '0;
`endif
        end else begin
            case (state)
                S_DRIVE:  settle_cnt <= '0;
                S_SETTLE: settle_cnt <= settle_cnt + 4'd1;
                S_SAMPLE: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 5'd1;
                        if (!first_err_vld) begin
                            first_err_vld <= 1'b1;
                            first_err_vec <= vector;
                        end
`ifdef F_CHK_ERR_MAP_EN
                        err_map[vector] <= 1'b1;
`endif
                    end
                    // Vector parks at 15 so vec_* read 4'b1111 throughout DONE.
                    if (vector == 4'hF) begin
                        busy <= 1'b0;
                    end else begin
                        vector <= vector + 4'd1;
                    end
                end
                S_DONE: begin
                    // err_cnt has settled by now, so pass reflects the final tally.
                    done <= 1'b1;
                    pass <= (err_cnt == 5'd0);
                end
                default: ;
            endcase
        end
    end

endmodule
